// File: rtl/gtech_reduce_pipe_if.sv
// ---------------------------------------------------------------------------
// gtech_reduce_pipe_if
//   Bundles the operand/result handshake of gtech_reduce_pipe.
//
//   A          operand, WIDTH bits
//   MODE       00 AND, 01 OR, 10 XOR, 11 reserved (reduced as AND)
//   INV        invert the final result
//   IN_VALID   operand valid            IN_READY   block accepts operand
//   Z          reduction result         OUT_VALID  Z valid
//   OUT_READY  downstream accepts Z
//   BUSY       any pipeline stage holds valid data
//   ERR        sticky flag: a MODE=11 operand was accepted
//
//   master: the side that supplies operands and consumes results.
//   slave : the reduction pipeline itself.
// ---------------------------------------------------------------------------
interface gtech_reduce_pipe_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [1:0]       MODE;
    logic             INV;
    logic             IN_VALID;
    logic             IN_READY;
    logic             Z;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             BUSY;
    logic             ERR;

    modport master (
        output A, MODE, INV, IN_VALID, OUT_READY,
        input  IN_READY, Z, OUT_VALID, BUSY, ERR
    );

    modport slave (
        input  A, MODE, INV, IN_VALID, OUT_READY,
        output IN_READY, Z, OUT_VALID, BUSY, ERR
    );
endinterface

// File: rtl/gtech_reduce_pipe.sv
// ---------------------------------------------------------------------------
// gtech_reduce_pipe
//   Pipelined WIDTH-input AND/OR/XOR reduction with optional output inversion
//   (NAND/NOR/XNOR). A FANIN-ary tree with one register level per tree level;
//   LAT = ceil(log_FANIN(WIDTH)) stages (minimum 1). Valid/ready flow control,
//   bubble-collapsing: a stage loads whenever it is empty or its content moves
//   on, so throughput is one operand per cycle and a stalled output lets the
//   upstream stages keep filling until every stage is occupied.
//
//   Ports
//     CP   clock, rising edge
//     RST  synchronous reset, active-high; clears all stage valids, Z and ERR
//     bus  gtech_reduce_pipe_if.slave: A, MODE, INV, IN_VALID, IN_READY,
//          Z, OUT_VALID, OUT_READY, BUSY, ERR
// ---------------------------------------------------------------------------
module gtech_reduce_pipe #(
    parameter int WIDTH = 4,
    parameter int FANIN = 4
) (
    input  logic                CP,
    input  logic                RST,
    gtech_reduce_pipe_if.slave  bus
);

    // Number of bits remaining after k tree levels: ceil(WIDTH / FANIN^k).
    function automatic int lvl_w(input int k);
        int n;
        n = WIDTH;
        for (int i = 0; i < k; i++) n = (n + FANIN - 1) / FANIN;
        return n;
    endfunction

    function automatic int calc_lat();
        int n;
        int l;
        n = WIDTH;
        l = 0;
        while (n > 1) begin
            n = (n + FANIN - 1) / FANIN;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    localparam int LAT = calc_lat();

    // Identity element used to pad the last, partially filled group:
    // 0 for OR/XOR, 1 for AND and for the reserved code (reduced as AND).
    function automatic logic pad_bit(input logic [1:0] m);
        return (m == 2'b01 || m == 2'b10) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic reduce_grp(input logic [FANIN-1:0] grp, input logic [1:0] m);
        logic r;
        case (m)
            2'b01:   r = |grp;
            2'b10:   r = ^grp;
            default: r = &grp;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Flow control (shared by all stages)
    // -----------------------------------------------------------------------
    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_in;
    logic [LAT-1:0] ld;
    logic           err_q;
    logic           accept;

    // Stage k loads when it is empty or stage k+1 (or the consumer, for the
    // last stage) takes its content this cycle. Unrolled from the output end
    // so each term is a plain OR with no loop through the vector itself.
    always_comb begin
        logic acc;
        ld  = '0;
        acc = bus.OUT_READY;
        for (int k = LAT - 1; k >= 0; k--) begin
            acc   = acc | !vld_q[k];
            ld[k] = acc;
        end
    end

    always_comb begin
        vld_in    = '0;
        vld_in[0] = bus.IN_VALID;
        for (int k = 1; k < LAT; k++) vld_in[k] = vld_q[k-1];
    end

    assign accept = bus.IN_VALID & ld[0];

    always_ff @(posedge CP) begin
        if (RST) begin
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= (vld_in & ld) | (vld_q & ~ld);
            if (accept && bus.MODE == 2'b11) err_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Data stages: stage k reduces a lvl_w(k)-bit vector to lvl_w(k+1) bits.
    // MODE and INV ride along so consecutive operands may use different modes.
    // -----------------------------------------------------------------------
    for (genvar gk = 0; gk < LAT; gk++) begin : g_stg
        localparam int IW = lvl_w(gk);
        localparam int OW = lvl_w(gk + 1);

        logic [IW-1:0]       din;
        logic [1:0]          m_in;
        logic                i_in;
        logic [OW*FANIN-1:0] pad;
        logic [OW-1:0]       red;
        logic [OW-1:0]       dq;

        // ---- stage boundary: inputs come from the port or the prior stage
        if (gk == 0) begin : g_src_port
            assign din  = bus.A;
            assign m_in = bus.MODE;
            assign i_in = bus.INV;
        end else begin : g_src_stage
            assign din  = g_stg[gk-1].dq;
            assign m_in = g_stg[gk-1].g_fwd.mq;
            assign i_in = g_stg[gk-1].g_fwd.iq;
        end

        always_comb begin
            pad           = {(OW*FANIN){pad_bit(m_in)}};
            pad[IW-1:0]   = din;
            red           = '0;
            for (int g = 0; g < OW; g++) red[g] = reduce_grp(pad[g*FANIN +: FANIN], m_in);
        end

        if (gk == LAT - 1) begin : g_last
            // ---- final stage register: Z is the inverted-or-not tree root
            always_ff @(posedge CP) begin
                if (RST) dq <= '0;
                else if (ld[gk]) dq <= red ^ {OW{i_in}};
            end
        end else begin : g_fwd
            // ---- intermediate stage register: partial vector plus controls
            logic [1:0] mq;
            logic       iq;
            always_ff @(posedge CP) begin
                if (ld[gk]) begin
                    dq <= red;
                    mq <= m_in;
                    iq <= i_in;
                end
            end
        end
    end

    assign bus.IN_READY  = ld[0];
    assign bus.Z         = g_stg[LAT-1].dq[0];
    assign bus.OUT_VALID = vld_q[LAT-1];
    assign bus.BUSY      = |vld_q;
    assign bus.ERR       = err_q;

endmodule
